mont_mult: RTL and testbench

MONT_MULT -- requirements
Module: mont_mult

---
 rtl/rsa_pkg.sv | 14 +
 rtl/mont_mult_step.sv | 22 ++
 rtl/mont_mult.sv | 105 ++++++++++
 tb/tb_mont_mult.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared RSA datapath constants and the Montgomery FSM state encoding.
package rsa_pkg;

  localparam int unsigned WIDTH = 2048;
  localparam int unsigned CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOOP = 2'b01,
    CORR = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/mont_mult_step.sv
// One radix-2 Montgomery iteration: S' = (S + a_i*b [+ n]) / 2.
module mont_mult_step #(
  parameter int unsigned WIDTH = rsa_pkg::WIDTH
) (
  input  logic [WIDTH+1:0] s,
  input  logic             a_i,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH+1:0] s_next
);

  logic [WIDTH+1:0] t_add;
  logic [WIDTH+1:0] t_odd;

  // With S < 2n and b < n the sum stays below 4n, so WIDTH+2 bits never overflow.
  always_comb begin
    t_add  = s + (a_i ? {2'b00, b} : '0);
    t_odd  = t_add[0] ? (t_add + {2'b00, n}) : t_add;
    s_next = t_odd >> 1;
  end

endmodule

// File: rtl/mont_mult.sv
// Iterative Montgomery multiplier: result = a*b*R^-1 mod n, R = 2^(n_len+1).
module mont_mult #(
  parameter int unsigned WIDTH = rsa_pkg::WIDTH,
  parameter int unsigned CNT_W = rsa_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  input  logic [10:0]      n_len,
  input  logic             enable,
  output logic [WIDTH-1:0] result,
  output logic             finish
);

  import rsa_pkg::*;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [CNT_W-1:0] k_q;
  logic [CNT_W-1:0] i_q;
  logic [WIDTH+1:0] s_q;
  logic [WIDTH+1:0] s_step;
  logic             a_i;
  logic             last_iter;
  logic             s_ge_n;

  mont_mult_step #(.WIDTH(WIDTH)) u_step (
    .s      (s_q),
    .a_i    (a_i),
    .b      (b_q),
    .n      (n_q),
    .s_next (s_step)
  );

  // Bit select via mask so iterations past WIDTH read a_i as 0.
  always_comb begin
    a_i       = |(a_q & (WIDTH'(1) << i_q));
    last_iter = (i_q == (k_q - CNT_W'(1)));
    s_ge_n    = (s_q >= {2'b00, n_q});
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; enable is only looked at in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = LOOP;
      LOOP:    if (last_iter) state_d = CORR;
      CORR:    state_d = DONE;
      DONE:    if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latches, accumulator, counter, final correction and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      k_q    <= '0;
      i_q    <= '0;
      s_q    <= '0;
      result <= '0;
      finish <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            a_q <= a;
            b_q <= b;
            n_q <= n;
            k_q <= CNT_W'(n_len) + CNT_W'(1);
            s_q <= '0;
            i_q <= '0;
          end
        end
        LOOP: begin
          s_q <= s_step;
          i_q <= i_q + CNT_W'(1);
        end
        CORR: begin
          // S < 2n, so one conditional subtraction lands in [0, n).
          result <= s_ge_n ? WIDTH'(s_q - {2'b00, n_q}) : s_q[WIDTH-1:0];
          finish <= 1'b1;
        end
        DONE: begin
          if (!enable) finish <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mult.sv
// Directed + random bench for mont_mult with an expected-result scoreboard.
module tb_mont_mult;

  import rsa_pkg::*;

  localparam int unsigned W = 2048;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] n;
  logic [10:0]  n_len;
  logic         enable;
  logic [W-1:0] result;
  logic         finish;

  int           checks;
  int           errors;
  logic [W-1:0] exp_q[$];

  mont_mult #(.WIDTH(W), .CNT_W(12)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .n      (n),
    .n_len  (n_len),
    .enable (enable),
    .result (result),
    .finish (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_w(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (low 128 bits)", tag, got[127:0], expv[127:0]);
    end
  endtask

  task automatic chk_i(input string tag, input int unsigned got, input int unsigned expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

  // Independent reference: (a*b mod n) by shift-and-add, then k modular halvings.
  function automatic logic [W-1:0] ref_mont(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic [W-1:0] rn, input int unsigned k);
    logic [W+1:0] x;
    logic [W+1:0] nn;
    nn = {2'b00, rn};
    x  = '0;
    for (int i = W - 1; i >= 0; i--) begin
      x = x << 1;
      if (x >= nn) x = x - nn;
      if (rb[i]) begin
        x = x + {2'b00, ra};
        if (x >= nn) x = x - nn;
      end
    end
    for (int unsigned j = 0; j < k; j++) begin
      if (x[0]) x = x + nn;
      x = x >> 1;
    end
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int unsigned w = 0; w < W / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Capture edge counts as edge 1; finish must be high after edge n_len+3.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] in_,
                        input logic [10:0] nl, input logic [W-1:0] expv, input bit chk_res,
                        input bit hold, input string tag);
    int unsigned  edges;
    bit           seen;
    logic [W-1:0] e;
    repeat (2) @(negedge clk);
    a = ia; b = ib; n = in_; n_len = nl; enable = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    edges = 1;
    #1;
    if (!hold) enable = 1'b0;
    a = '1; b = '1; n = ia; n_len = 11'h7ff;
    seen = 1'b0;
    while (!seen && edges < 32'(nl) + 8) begin
      @(posedge clk);
      edges++;
      #1;
      seen = finish;
    end
    chk_i({tag, "_latency"}, edges, 32'(nl) + 3);
    e = exp_q.pop_front();
    if (seen && chk_res) chk_w({tag, "_result"}, result, e);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rn;
    checks = 0;
    errors = 0;
    a = '0; b = '0; n = '0; n_len = '0; enable = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk_w("reset_result", result, '0);
    chk_i("reset_finish", 32'(finish), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    run_op(2048'd5,  2048'd7,  2048'd13, 11'd3, 2048'd3, 1'b1, 1'b0, "m5x7");
    run_op(2048'd1,  2048'd3,  2048'd13, 11'd3, 2048'd1, 1'b1, 1'b0, "identity");

    // a=0 with enable held: DONE must persist without a restart.
    run_op(2048'd0,  2048'd7,  2048'd13, 11'd3, 2048'd0, 1'b1, 1'b1, "zero_hold");
    repeat (3) begin
      @(posedge clk); #1;
      chk_i("hold_finish", 32'(finish), 1);
      chk_i("hold_state", 32'(dut.state_q), 32'(DONE));
    end
    enable = 1'b0;
    @(posedge clk); #1;
    chk_i("drop_finish", 32'(finish), 0);
    chk_i("drop_state", 32'(dut.state_q), 32'(IDLE));
    chk_w("drop_result", result, 2048'd0);

    run_op(2048'd12, 2048'd12, 2048'd13, 11'd3, 2048'd9, 1'b1, 1'b0, "corr12x12");

    // Reset during the third LOOP cycle clears outputs without waiting for clk.
    repeat (2) @(negedge clk);
    a = 2048'd5; b = 2048'd7; n = 2048'd13; n_len = 11'd3; enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk_w("async_rst_result", result, '0);
    chk_i("async_rst_finish", 32'(finish), 0);
    chk_i("async_rst_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(posedge clk);
    #1 chk_i("rst_held_finish", 32'(finish), 0);
    @(negedge clk) rst = 1'b1;

    run_op(2048'd5, 2048'd7, 2048'd13, 11'd3, 2048'd3, 1'b1, 1'b0, "after_rst");
    run_op(2048'd0, 2048'd0, 2048'd1,  11'd0, 2048'd0, 1'b1, 1'b0, "k1");
    run_op(2048'd5, 2048'd7, 2048'd12, 11'd3, 2048'd0, 1'b0, 1'b0, "even_n");

    for (int t = 0; t < 2; t++) begin
      rn = rand_w();
      rn[W-1] = 1'b1;
      rn[0]   = 1'b1;
      ra = rand_w(); ra[W-1] = 1'b0;
      rb = rand_w(); rb[W-1] = 1'b0;
      run_op(ra, rb, rn, 11'd2047, ref_mont(ra, rb, rn, 2048), 1'b1, 1'b0, "rand2048");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
